// File: rtl/mem_stream_reader_pkg.sv
// Shared types and parameter-legality helpers for the RAM-to-stream burst reader.
package mem_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;

    function automatic bit rd_latency_legal(input int lat);
        return (lat == RD_LATENCY_MIN) || (lat == RD_LATENCY_MAX);
    endfunction

    // The FIFO must hold every in-flight read plus one word being popped.
    function automatic bit fifo_depth_legal(input int depth, input int lat);
        return (depth >= lat + 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_stream_reader_if.sv
// Output stream of the burst reader: data, last marker and valid/ready handshake.
interface mem_stream_reader_if #(
    parameter int DATA_WIDTH = 8
) ();

    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_valid_o;
    logic                  m_last_o;
    logic                  m_ready_i;

    modport master (
        output m_data_o,
        output m_valid_o,
        output m_last_o,
        input  m_ready_i
    );

    modport slave (
        input  m_data_o,
        input  m_valid_o,
        input  m_last_o,
        output m_ready_i
    );

endinterface

// File: rtl/mem_stream_reader_fifo.sv
// First-word fall-through FIFO holding {last, data}; output reads as zero when empty.
module stream_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/mem_stream_reader.sv
// Reads a burst of words from a synchronous RAM read port and presents them as a
// valid/ready stream, issuing reads only when the output FIFO has room for them.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    input  logic [ADDR_WIDTH:0]   length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    input  logic                  rd_data_valid_i,
    mem_stream_reader_if.master   m
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0]    DEPTH_LIM = SUM_W'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] LEN_ONE   = (ADDR_WIDTH + 1)'(1);

    if (!rd_latency_legal(RD_LATENCY) || !fifo_depth_legal(FIFO_DEPTH, RD_LATENCY)) begin : g_param_check
        $error("mem_stream_reader: illegal RD_LATENCY / FIFO_DEPTH combination");
    end

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   issue_left;
    logic [ADDR_WIDTH:0]   recv_left;
    logic [CNT_W-1:0]      outstanding;
    logic [CNT_W-1:0]      fifo_count;
    logic                  zero_done;

    logic                  issue;
    logic                  accept;
    logic                  push_last;
    logic                  pop;
    logic                  fifo_empty;
    logic                  burst_end;
    logic [DATA_WIDTH:0]   fifo_out;
    logic [SUM_W-1:0]      credit_used;

    // Every issued read already owns a FIFO slot, so the FIFO cannot overflow.
    assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
    assign issue       = (state == ST_READ) && (issue_left != '0) && (credit_used < DEPTH_LIM);
    assign accept      = rd_data_valid_i && (outstanding != '0);
    assign push_last   = (recv_left == LEN_ONE);
    assign pop         = m.m_valid_o && m.m_ready_i;
    assign burst_end   = (state == ST_DRAIN) && pop && m.m_last_o;

    assign busy_o    = (state != ST_IDLE);
    assign done_o    = zero_done || burst_end;
    assign rd_en_o   = issue;
    assign rd_addr_o = addr;

    assign m.m_valid_o = !fifo_empty;
    assign {m.m_last_o, m.m_data_o} = fifo_out;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= ST_IDLE;
            addr       <= '0;
            issue_left <= '0;
            recv_left  <= '0;
            zero_done  <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (accept && (recv_left != '0)) recv_left <= recv_left - LEN_ONE;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (length_i != '0) begin
                            state      <= ST_READ;
                            addr       <= start_addr_i;
                            issue_left <= length_i;
                            recv_left  <= length_i;
                        end else begin
                            zero_done <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr       <= addr + ADDR_WIDTH'(1);
                        issue_left <= issue_left - LEN_ONE;
                        if (issue_left == LEN_ONE) state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (burst_end) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Reads in flight; returns arriving with nothing outstanding are stale and ignored.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            outstanding <= '0;
        end else begin
            case ({issue, accept})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .push      (accept),
        .push_data ({push_last, rd_data_i}),
        .pop       (pop),
        .pop_data  (fifo_out),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader: two instances (RD_LATENCY 1 and 2), each
// fed by a RAM model holding mem[a]=a, exercised one at a time with directed bursts.
module tb_mem_stream_reader;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int FD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW:0]   length = '0;
    logic          ready = 1'b1;
    int            cur = 0;

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] exp_q[$];
    logic [7:0] last_addrs[$];
    logic [7:0] ram [256];

    // ---------------- instance with RD_LATENCY = 1
    logic          start0, busy0, done0, rd_en0;
    logic [AW-1:0] ra0;
    logic [DW-1:0] rd0 = '0;
    logic          rv0 = 1'b0;
    mem_stream_reader_if #(.DATA_WIDTH(DW)) sif0 ();
    assign start0 = start && (cur == 0);
    assign sif0.m_ready_i = ready;

    mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .FIFO_DEPTH(FD)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .start_addr_i(start_addr),
        .length_i(length), .busy_o(busy0), .done_o(done0), .rd_en_o(rd_en0),
        .rd_addr_o(ra0), .rd_data_i(rd0), .rd_data_valid_i(rv0), .m(sif0.master));

    always @(posedge clk) begin
        rd0 <= ram[ra0];
        rv0 <= rd_en0;
    end

    // ---------------- instance with RD_LATENCY = 2
    logic          start1, busy1, done1, rd_en1;
    logic [AW-1:0] ra1;
    logic [DW-1:0] rd1 = '0, d1a = '0;
    logic          rv1 = 1'b0, v1a = 1'b0;
    mem_stream_reader_if #(.DATA_WIDTH(DW)) sif1 ();
    assign start1 = start && (cur == 1);
    assign sif1.m_ready_i = ready;

    mem_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(2), .FIFO_DEPTH(FD)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .start_addr_i(start_addr),
        .length_i(length), .busy_o(busy1), .done_o(done1), .rd_en_o(rd_en1),
        .rd_addr_o(ra1), .rd_data_i(rd1), .rd_data_valid_i(rv1), .m(sif1.master));

    always @(posedge clk) begin
        d1a <= ram[ra1];
        v1a <= rd_en1;
        rd1 <= d1a;
        rv1 <= v1a;
    end

    // ---------------- view of the instance under test
    logic          s_busy, s_done, s_rd_en, s_valid, s_last;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_data;
    always_comb begin
        s_busy  = (cur == 0) ? busy0 : busy1;
        s_done  = (cur == 0) ? done0 : done1;
        s_rd_en = (cur == 0) ? rd_en0 : rd_en1;
        s_addr  = (cur == 0) ? ra0 : ra1;
        s_valid = (cur == 0) ? sif0.m_valid_o : sif1.m_valid_o;
        s_last  = (cur == 0) ? sif0.m_last_o : sif1.m_last_o;
        s_data  = (cur == 0) ? sif0.m_data_o : sif1.m_data_o;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- monitor: pops expected beats, checks hold under back-pressure
    logic [8:0] prev_beat = '0;
    logic       prev_stall = 1'b0;
    always @(negedge clk) begin
        if (rst_n && s_valid) begin
            if (prev_stall) chk("beat_hold", int'({s_last, s_data}), int'(prev_beat));
            if (ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", {s_last, s_data});
                end else begin
                    chk("beat", int'({s_last, s_data}), int'(exp_q.pop_front()));
                end
            end
        end
        prev_stall = rst_n && s_valid && !ready;
        prev_beat  = {s_last, s_data};
    end

    // ---------------- read-credit model: reads in flight plus FIFO words never exceed FD
    int out_m[2] = '{0, 0};
    int occ_m[2] = '{0, 0};
    logic [1:0] en_v, rv_v, pop_v;
    assign en_v  = {rd_en1, rd_en0};
    assign rv_v  = {rv1, rv0};
    assign pop_v = {sif1.m_valid_o & ready, sif0.m_valid_o & ready};
    always @(negedge clk) begin
        if (!rst_n) begin
            out_m = '{0, 0};
            occ_m = '{0, 0};
        end else begin
            for (int g = 0; g < 2; g++) begin
                bit acc;
                if (en_v[g]) chk($sformatf("credit_lat%0d", g + 1), int'(out_m[g] + occ_m[g] < FD), 1);
                acc = rv_v[g] && (out_m[g] > 0);
                out_m[g] = out_m[g] + int'(en_v[g]) - int'(acc);
                occ_m[g] = occ_m[g] + int'(acc) - int'(pop_v[g]);
            end
        end
    end

    function automatic logic pat(input int mode, input int k);
        return (mode == 0) ? 1'b1 : ((k % 4) == 0);
    endfunction

    task automatic check_outputs_zero(input string name);
        chk(name, int'({s_busy, s_done, s_rd_en, s_addr, s_valid, s_last, s_data}), 0);
    endtask

    // One burst: k counts cycles after the start_i cycle (k=1 is the first busy cycle).
    task automatic run_burst(input logic [7:0] a, input logic [8:0] len, input int mode,
                             input bit restart, input int rst_at, input int exp_first,
                             input int exp_done, input string tag);
        int first = -1, donek = -1, dones = 0, en_cnt = 0, beats = 0;
        logic busy_at1 = 1'b0;
        last_addrs.delete();
        for (int i = 0; i < int'(len); i++) begin
            logic [7:0] d;
            logic       lst;
            d   = a + 8'(i);
            lst = (i == int'(len) - 1);
            exp_q.push_back({lst, d});
        end
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; length = len; ready = pat(mode, 0);
        @(posedge clk); #1;
        start = 1'b0; ready = pat(mode, 1);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) busy_at1 = s_busy;
            if (s_valid && first < 0) first = k;
            if (s_valid && ready) beats++;
            if (s_rd_en) begin
                en_cnt++;
                last_addrs.push_back(s_addr);
            end
            if (s_done) begin
                dones++;
                if (donek < 0) donek = k;
            end
            if (donek > 0 && k >= donek + 3) break;
            @(posedge clk); #1;
            ready = pat(mode, k + 1);
            start = restart && (k + 1 == 3);
            if (start) begin
                start_addr = 8'h80;
                length = 9'd2;
            end
            if (rst_at == k + 1) begin
                rst_n = 1'b0;
                #1;
                check_outputs_zero({tag, "_reset_outputs"});
                exp_q.delete();
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        chk({tag, "_done_seen"}, int'(donek > 0), 1);
        chk({tag, "_done_count"}, dones, 1);
        chk({tag, "_beat_count"}, beats, int'(len));
        chk({tag, "_rd_en_count"}, en_cnt, int'(len));
        chk({tag, "_busy_k1"}, int'(busy_at1), int'(len != 0));
        chk({tag, "_queue_left"}, exp_q.size(), 0);
        if (exp_first > 0) chk({tag, "_first_valid_cycle"}, first, exp_first);
        if (len == 0) chk({tag, "_no_valid"}, first, -1);
        if (exp_done > 0) chk({tag, "_done_cycle"}, donek, exp_done);
        exp_q.delete();
    endtask

    logic [7:0] wrap_tab [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'(i);
        for (int l = 0; l < 2; l++) begin
            cur   = l;
            rst_n = 1'b0;
            ready = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            check_outputs_zero($sformatf("lat%0d_reset_state", l + 1));
            @(posedge clk); #1;
            rst_n = 1'b1;
            repeat (2) @(posedge clk);

            // lat+2 to first beat, last beat (and done) 3 cycles later
            run_burst(8'h10, 9'd4, 0, 1'b0, 0, l + 3, l + 6, $sformatf("lat%0d_basic", l + 1));
            run_burst(8'hFE, 9'd4, 0, 1'b0, 0, l + 3, l + 6, $sformatf("lat%0d_wrap", l + 1));
            chk($sformatf("lat%0d_wrap_addr_count", l + 1), last_addrs.size(), 4);
            for (int i = 0; i < 4 && i < last_addrs.size(); i++)
                chk($sformatf("lat%0d_wrap_addr%0d", l + 1, i), int'(last_addrs[i]), int'(wrap_tab[i]));
            run_burst(8'h00, 9'd16, 1, 1'b0, 0, l + 3, 0, $sformatf("lat%0d_backpressure", l + 1));
            run_burst(8'h33, 9'd0, 0, 1'b0, 0, 0, 1, $sformatf("lat%0d_zero_len", l + 1));
            run_burst(8'h50, 9'd8, 0, 1'b1, 0, l + 3, l + 10, $sformatf("lat%0d_restart_ignored", l + 1));
            run_burst(8'h40, 9'd8, 0, 1'b0, 4, 0, 0, $sformatf("lat%0d_midburst", l + 1));
            for (int q = 0; q < 4; q++) begin
                @(negedge clk);
                chk($sformatf("lat%0d_post_reset_quiet", l + 1), int'({s_done, s_valid, s_busy}), 0);
            end
            run_burst(8'h20, 9'd2, 0, 1'b0, 0, l + 3, l + 4, $sformatf("lat%0d_after_reset", l + 1));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
